// File: rtl/im_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer (im_fetch_ctrl).
package im_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // 33-bit offset keeps the upper-bound test immune to 32-bit wrap.
  function automatic logic pc_in_range(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, pc} - {1'b0, base};
    return (pc >= base) && (off < span);
  endfunction

endpackage

// File: rtl/im_fetch_fifo.sv
// Prefetch FIFO for im_fetch_ctrl: synchronous, power-of-two depth, with flush.
module im_fetch_fifo
  import im_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, fills a prefetch FIFO, handles
// redirects, halt and illegal-address faults. Optional counters: IM_FETCH_PERF_EN.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IM_WORDS   = 4096,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  state_o
`ifdef IM_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] IM_SPAN = 33'(IM_WORDS) << 2;

  state_t       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;
  logic         fault_q, fault_d;
  logic         flush;
  logic         push;
  logic         pop;
  logic         redirect_act;
  logic         redirect_bad;
  logic         can_fetch;
  logic [31:0]  next_seq;
  fetch_entry_t head;
  logic [CW-1:0] count;
  logic         empty;

  // Handshake: the head transfers on any cycle with out_valid && out_ready;
  // out_valid never depends on out_ready, and a redirect cancels that cycle's transfer.
  assign redirect_act = redirect_valid && (state_q == ST_RUN || state_q == ST_HALT);
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || !pc_in_range(redirect_pc, RESET_PC, IM_SPAN);
  assign pop          = out_valid && out_ready && !redirect_act;
  assign can_fetch    = (state_q == ST_RUN) && !redirect_act && !halt_req &&
                        ((count < CW'(FIFO_DEPTH)) || pop);
  assign push         = can_fetch;
  assign next_seq     = pc_q + PC_INC;

  im_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ('{pc: pc_q, instr: im_instr}),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    flush      = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HALT: begin
        if (redirect_act) begin
          flush = 1'b1;
          if (redirect_bad) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (state_q == ST_RUN) begin
          if (halt_req) begin
            state_d = ST_HALT;
          end else if (can_fetch) begin
            pc_d = next_seq;
            // The address past the end is never fetched; it becomes the fault address.
            if (!pc_in_range(next_seq, RESET_PC, IM_SPAN)) begin
              state_d    = ST_FAULT;
              fault_d    = 1'b1;
              fault_pc_d = next_seq;
            end
          end
        end else if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  assign im_addr   = pc_q;
  assign out_valid = !empty;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign state_o   = state_q;

`ifdef IM_FETCH_PERF_EN
  logic [32:0] flush_sum;
  assign flush_sum = {1'b0, flush_cnt} + 33'(count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
      if (flush) flush_cnt <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end
`endif

endmodule
